// File: rtl/grant_router.sv
// grant_router: takes a one-hot grant from the 4-client arbiter and latches the
// granted client as owner of one shared output channel. It routes the owner's
// valid/data onto that channel and passes the sink's ready back to the owner.
// A tenure is capped at MAX_BEATS accepted beats. At tenure end the owner gets
// a one-cycle done pulse. A multi-hot grant seen in IDLE raises err_multi_gnt.
//
// Optional feature, enabled with the macro GRANT_ROUTER_STATS_EN:
//   adds stat_beats[15:0], a saturating count of accepted beats since reset.
//
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both high. In OWN, out_valid is valid_owner gated by gnt_owner.
// ready_owner is out_ready gated by gnt_owner, so the client and the sink see
// the same transfer. Every other ready stays low.
module grant_router #(
    parameter int DW        = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gnt_0,
    input  logic          gnt_1,
    input  logic          gnt_2,
    input  logic          gnt_3,
    input  logic          valid_0,
    input  logic          valid_1,
    input  logic          valid_2,
    input  logic          valid_3,
    input  logic [DW-1:0] data_0,
    input  logic [DW-1:0] data_1,
    input  logic [DW-1:0] data_2,
    input  logic [DW-1:0] data_3,
    output logic          ready_0,
    output logic          ready_1,
    output logic          ready_2,
    output logic          ready_3,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    out_owner,
    output logic          busy,
    output logic          done_0,
    output logic          done_1,
    output logic          done_2,
    output logic          done_3,
    output logic          err_multi_gnt,
`ifdef GRANT_ROUTER_STATS_EN
    output logic [15:0]   stat_beats,
`endif
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] BEAT_CAP = MAX_BEATS[7:0];

    state_t          state, state_next;
    logic [7:0]      beat_cnt;
    logic [1:0]      owner;
    logic            err_q;
    logic [3:0]      gnt_vec;
    logic [3:0]      valid_vec;
    logic [DW-1:0]   data_arr [4];
    logic [3:0]      ready_vec;
    logic [3:0]      done_vec;
    logic            gnt_multi;
    logic            gnt_any;
    logic [1:0]      gnt_idx;
    logic            gnt_owner;
    logic            valid_owner;
    logic            accept;
    logic            cap_hit;

    assign gnt_vec     = {gnt_3, gnt_2, gnt_1, gnt_0};
    assign valid_vec   = {valid_3, valid_2, valid_1, valid_0};
    assign data_arr[0] = data_0;
    assign data_arr[1] = data_1;
    assign data_arr[2] = data_2;
    assign data_arr[3] = data_3;

    // Clearing the lowest set bit leaves something only when two or more grants are high.
    assign gnt_any     = |gnt_vec;
    assign gnt_multi   = |(gnt_vec & (gnt_vec - 4'd1));
    assign gnt_owner   = gnt_vec[owner];
    assign valid_owner = valid_vec[owner];
    assign accept      = (state == OWN) && valid_owner && gnt_owner && out_ready;
    assign cap_hit     = accept && ((beat_cnt + 8'd1) == BEAT_CAP);

    // Encode the granted client index; only used when exactly one grant is high.
    always_comb begin
        gnt_idx = 2'd0;
        case (gnt_vec)
            4'b0010: gnt_idx = 2'd1;
            4'b0100: gnt_idx = 2'd2;
            4'b1000: gnt_idx = 2'd3;
            default: gnt_idx = 2'd0;
        endcase
    end

    // State register; reset aborts any tenure without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: a tenure ends on the beat cap or when the owner loses its grant.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_any && !gnt_multi) state_next = OWN;
            OWN:     if (cap_hit || !gnt_owner) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: the channel is only connected to the owner while in OWN.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        ready_vec = 4'b0000;
        done_vec  = 4'b0000;
        case (state)
            OWN: begin
                out_valid        = valid_owner & gnt_owner;
                out_data         = data_arr[owner];
                ready_vec[owner] = out_ready & gnt_owner;
            end
            RELEASE: done_vec[owner] = 1'b1;
            default: ;
        endcase
    end

    // Owner and beat counter are loaded on IDLE->OWN; the counter advances on each accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner    <= 2'd0;
            beat_cnt <= 8'd0;
        end else if (state == IDLE && gnt_any && !gnt_multi) begin
            owner    <= gnt_idx;
            beat_cnt <= 8'd0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    // A multi-hot grant sampled in IDLE gives a one-cycle error pulse on the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= (state == IDLE) && gnt_multi;
    end

`ifdef GRANT_ROUTER_STATS_EN
    logic [15:0] stat_q;

    // Saturating count of every accepted beat since reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        stat_q <= 16'd0;
        else if (accept && stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
    end

    assign stat_beats = stat_q;
`endif

    assign ready_0       = ready_vec[0];
    assign ready_1       = ready_vec[1];
    assign ready_2       = ready_vec[2];
    assign ready_3       = ready_vec[3];
    assign done_0        = done_vec[0];
    assign done_1        = done_vec[1];
    assign done_2        = done_vec[2];
    assign done_3        = done_vec[3];
    assign out_owner     = owner;
    assign busy          = (state != IDLE);
    assign err_multi_gnt = err_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_grant_router.sv
// Directed bench for grant_router (DW=8, MAX_BEATS=4). Inputs are driven 1ns
// after the rising edge and outputs are checked 2ns after it.
module tb_grant_router;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    logic       clk;
    logic       reset;
    logic [3:0] gnt;
    logic [3:0] valid;
    logic [7:0] data [4];
    logic       out_ready;
    wire  [3:0] ready_w;
    wire  [3:0] done_w;
    wire        out_valid;
    wire  [7:0] out_data;
    wire  [1:0] out_owner;
    wire        busy;
    wire        err_multi_gnt;
    wire  [1:0] dbg_state;
`ifdef GRANT_ROUTER_STATS_EN
    wire  [15:0] stat_beats;
`endif

    int checks = 0;
    int errors = 0;

    grant_router #(.DW(8), .MAX_BEATS(4)) dut (
        .clk(clk), .reset(reset),
        .gnt_0(gnt[0]), .gnt_1(gnt[1]), .gnt_2(gnt[2]), .gnt_3(gnt[3]),
        .valid_0(valid[0]), .valid_1(valid[1]), .valid_2(valid[2]), .valid_3(valid[3]),
        .data_0(data[0]), .data_1(data[1]), .data_2(data[2]), .data_3(data[3]),
        .ready_0(ready_w[0]), .ready_1(ready_w[1]), .ready_2(ready_w[2]), .ready_3(ready_w[3]),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_owner(out_owner), .busy(busy),
        .done_0(done_w[0]), .done_1(done_w[1]), .done_2(done_w[2]), .done_3(done_w[3]),
        .err_multi_gnt(err_multi_gnt),
`ifdef GRANT_ROUTER_STATS_EN
        .stat_beats(stat_beats),
`endif
        .dbg_state(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // advance to 1ns after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        gnt       = 4'b0000;
        valid     = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) data[i] = 8'h00;

        // reset state
        #3;
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_owner", 32'(out_owner), 32'd0);
        check("rst_ready", 32'(ready_w), 32'd0);
        check("rst_done", 32'(done_w), 32'd0);
        check("rst_err", 32'(err_multi_gnt), 32'd0);
        step();
        reset = 1'b1;

        // tenure 1: client 2, four beats of A5 with a steady sink
        gnt = 4'b0100; valid = 4'b0100; data[2] = 8'hA5; out_ready = 1'b1;
        #1;
        check("t1_idle_valid", 32'(out_valid), 32'd0);
        check("t1_idle_ready", 32'(ready_w), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            check("t1_state", 32'(dbg_state), 32'(S_OWN));
            check("t1_owner", 32'(out_owner), 32'd2);
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_data", 32'(out_data), 32'hA5);
            check("t1_ready", 32'(ready_w), 32'b0100);
            check("t1_done", 32'(done_w), 32'd0);
        end
        step();
        gnt = 4'b0000; valid = 4'b0000;
        #1;
        check("t1_rel_state", 32'(dbg_state), 32'(S_REL));
        check("t1_rel_done", 32'(done_w), 32'b0100);
        check("t1_rel_valid", 32'(out_valid), 32'd0);
        check("t1_rel_ready", 32'(ready_w), 32'd0);
        check("t1_rel_busy", 32'(busy), 32'd1);
        step(); #1;
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_done", 32'(done_w), 32'd0);
        check("t1_idle_owner", 32'(out_owner), 32'd2);

        // tenure 2: client 1, sink ready toggling 1,0,1,0...
        gnt = 4'b0010; valid = 4'b0010; data[1] = 8'h3C; out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            out_ready = (i % 2 == 0);
            #1;
            check("t2_state", 32'(dbg_state), 32'(S_OWN));
            check("t2_ready", 32'(ready_w), {30'd0, out_ready, 1'b0});
            check("t2_valid", 32'(out_valid), 32'd1);
            check("t2_data", 32'(out_data), 32'h3C);
        end
        step();
        gnt = 4'b0000; valid = 4'b0000; out_ready = 1'b1;
        #1;
        check("t2_rel_state", 32'(dbg_state), 32'(S_REL));
        check("t2_rel_done", 32'(done_w), 32'b0010);
`ifdef GRANT_ROUTER_STATS_EN
        check("t2_stat", 32'(stat_beats), 32'd8);
`endif
        step(); #1;
        check("t2_idle_state", 32'(dbg_state), 32'(S_IDLE));

        // multi-hot grant in IDLE
        gnt = 4'b0101;
        step();
        gnt = 4'b0000;
        #1;
        check("mg_err", 32'(err_multi_gnt), 32'd1);
        check("mg_state", 32'(dbg_state), 32'(S_IDLE));
        check("mg_owner", 32'(out_owner), 32'd1);
        check("mg_busy", 32'(busy), 32'd0);
        step(); #1;
        check("mg_err_clr", 32'(err_multi_gnt), 32'd0);
        check("mg_state2", 32'(dbg_state), 32'(S_IDLE));

        // tenure 3: client 0, grant dropped after two beats with valid still high
        gnt = 4'b0001; valid = 4'b0001; data[0] = 8'h5A; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            check("t3_valid", 32'(out_valid), 32'd1);
            check("t3_data", 32'(out_data), 32'h5A);
        end
        step();
        gnt = 4'b0000;
        #1;
        check("t3_drop_state", 32'(dbg_state), 32'(S_OWN));
        check("t3_drop_valid", 32'(out_valid), 32'd0);
        check("t3_drop_ready", 32'(ready_w), 32'd0);
        step();
        valid = 4'b0000;
        #1;
        check("t3_rel_state", 32'(dbg_state), 32'(S_REL));
        check("t3_rel_done", 32'(done_w), 32'b0001);
        step(); #1;
        check("t3_idle_state", 32'(dbg_state), 32'(S_IDLE));
`ifdef GRANT_ROUTER_STATS_EN
        check("t3_stat", 32'(stat_beats), 32'd10);
`endif

        // tenure 4: client 3, reset asserted mid-tenure after one beat
        gnt = 4'b1000; valid = 4'b1000; data[3] = 8'h77; out_ready = 1'b1;
        step(); #1;
        check("t4_owner", 32'(out_owner), 32'd3);
        check("t4_valid", 32'(out_valid), 32'd1);
        step(); #1;
        reset = 1'b0;
        #1;
        check("t4_rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_valid", 32'(out_valid), 32'd0);
        check("t4_rst_data", 32'(out_data), 32'd0);
        check("t4_rst_ready", 32'(ready_w), 32'd0);
        check("t4_rst_done", 32'(done_w), 32'd0);
        check("t4_rst_owner", 32'(out_owner), 32'd0);
`ifdef GRANT_ROUTER_STATS_EN
        check("t4_rst_stat", 32'(stat_beats), 32'd0);
`endif
        gnt = 4'b0000; valid = 4'b0000;
        step();
        reset = 1'b1;
        step(); #1;
        check("t4_post_state", 32'(dbg_state), 32'(S_IDLE));
        check("t4_post_done", 32'(done_w), 32'd0);
        check("t4_post_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
